// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the seven-segment scan driver.
//   - 4-bit glyph codes GLYPH_L .. GLYPH_BLANK
//   - 7-bit active-low segment patterns, a..g on bits [6]..[0]
//   - SEG_OFF: every segment dark
package seg_pkg;

  localparam logic [3:0] GLYPH_L     = 4'd0;
  localparam logic [3:0] GLYPH_U     = 4'd1;
  localparam logic [3:0] GLYPH_F     = 4'd2;
  localparam logic [3:0] GLYPH_O     = 4'd3;
  localparam logic [3:0] GLYPH_P     = 4'd4;
  localparam logic [3:0] GLYPH_E     = 4'd5;
  localparam logic [3:0] GLYPH_N     = 4'd6;
  localparam logic [3:0] GLYPH_DASH  = 4'd7;
  localparam logic [3:0] GLYPH_A     = 4'd8;
  localparam logic [3:0] GLYPH_C     = 4'd9;
  localparam logic [3:0] GLYPH_H     = 4'd10;
  localparam logic [3:0] GLYPH_R     = 4'd11;
  localparam logic [3:0] GLYPH_T     = 4'd12;
  localparam logic [3:0] GLYPH_D     = 4'd13;
  localparam logic [3:0] GLYPH_S     = 4'd14;
  localparam logic [3:0] GLYPH_BLANK = 4'd15;

  localparam logic [6:0] SEG_L    = 7'b1110001;
  localparam logic [6:0] SEG_U    = 7'b1000001;
  localparam logic [6:0] SEG_F    = 7'b0111000;
  localparam logic [6:0] SEG_O    = 7'b0000001;
  localparam logic [6:0] SEG_P    = 7'b0011000;
  localparam logic [6:0] SEG_E    = 7'b0110000;
  localparam logic [6:0] SEG_N    = 7'b1101010;
  localparam logic [6:0] SEG_DASH = 7'b1111110;
  localparam logic [6:0] SEG_A    = 7'b0001000;
  localparam logic [6:0] SEG_C    = 7'b0110001;
  localparam logic [6:0] SEG_H    = 7'b1001000;
  localparam logic [6:0] SEG_R    = 7'b1111010;
  localparam logic [6:0] SEG_T    = 7'b1110000;
  localparam logic [6:0] SEG_D    = 7'b1000010;
  localparam logic [6:0] SEG_S    = 7'b0100100;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/seg_glyph_rom.sv
// seg_glyph_rom: combinational glyph code -> active-low segment pattern.
// Ports:
//   code_i  in  4  glyph code
//   seg_o   out 7  segments a..g on [6]..[0], 0 = lit
module seg_glyph_rom
  import seg_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    case (code_i)
      GLYPH_L:     seg_o = SEG_L;
      GLYPH_U:     seg_o = SEG_U;
      GLYPH_F:     seg_o = SEG_F;
      GLYPH_O:     seg_o = SEG_O;
      GLYPH_P:     seg_o = SEG_P;
      GLYPH_E:     seg_o = SEG_E;
      GLYPH_N:     seg_o = SEG_N;
      GLYPH_DASH:  seg_o = SEG_DASH;
      GLYPH_A:     seg_o = SEG_A;
      GLYPH_C:     seg_o = SEG_C;
      GLYPH_H:     seg_o = SEG_H;
      GLYPH_R:     seg_o = SEG_R;
      GLYPH_T:     seg_o = SEG_T;
      GLYPH_D:     seg_o = SEG_D;
      GLYPH_S:     seg_o = SEG_S;
      default:     seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed seven-segment driver for NUM_DIGITS digits
// sharing one active-low segment bus, one active-low anode per digit.
// Glyphs are double buffered: loads land in a pending buffer that is promoted
// to the displayed (active) buffer only when the scan wraps to digit 0.
// Each digit slot starts with GUARD_CYC cycles of all anodes off while the
// segment bus already carries the new digit's pattern (anti-ghosting).
// Optional macro SEG_BLINK_EN adds the blink_mask port and a blink phase that
// toggles every BLINK_FRAMES frames.
// Ports:
//   clk         in  1            clock
//   reset       in  1            async, active-high
//   glyph_bus   in  NUM_DIGITS*4 glyph codes, digit i = [4i+3:4i], digit 0 rightmost
//   load        in  1            capture glyph_bus/blank_mask
//   blank_mask  in  NUM_DIGITS   1 = force digit dark (captured with load)
//   blink_mask  in  NUM_DIGITS   1 = digit blinks (SEG_BLINK_EN only, live)
//   seg         out 7            a..g on [6]..[0], 0 = lit
//   an          out NUM_DIGITS   anode enables, 0 = on
//   frame_done  out 1            pulse in the cycle the index becomes 0
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD_CYC   = 16
`ifdef SEG_BLINK_EN
  , parameter int BLINK_FRAMES = 64
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_DIGITS*4-1:0] glyph_bus,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
`ifdef SEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int SW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [SW-1:0] SLOT_TC   = SW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] GUARD_END = SW'(GUARD_CYC);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  typedef logic [NUM_DIGITS-1:0][3:0] glyphs_t;

  logic [SW-1:0]         slot_q, slot_d;
  logic [IW-1:0]         idx_q, idx_d;
  glyphs_t               act_glyph_q, act_glyph_d;
  glyphs_t               pend_glyph_q, pend_glyph_d;
  logic [NUM_DIGITS-1:0] act_blank_q, act_blank_d;
  logic [NUM_DIGITS-1:0] pend_blank_q, pend_blank_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  fd_q, fd_d;

  glyphs_t    bus_glyph;
  logic       tc, wrap;
  logic [6:0] rom_seg;
  logic       blink_hide;

  assign bus_glyph = glyph_bus;
  assign tc        = (slot_q == SLOT_TC);
  assign wrap      = tc && (idx_q == IDX_LAST);

  seg_glyph_rom u_rom (
    .code_i (act_glyph_q[idx_q]),
    .seg_o  (rom_seg)
  );

`ifdef SEG_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FW-1:0] fcnt_q;
  logic          phase_q;

  // Counts frame_done pulses; phase 1 hides blinking digits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fcnt_q  <= '0;
      phase_q <= 1'b0;
    end else if (fd_q) begin
      if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
        fcnt_q  <= '0;
        phase_q <= ~phase_q;
      end else begin
        fcnt_q  <= fcnt_q + 1'b1;
      end
    end
  end

  assign blink_hide = phase_q & blink_mask[idx_q];
`else
  assign blink_hide = 1'b0;
`endif

  always_comb begin
    slot_d       = slot_q + 1'b1;
    idx_d        = idx_q;
    act_glyph_d  = act_glyph_q;
    act_blank_d  = act_blank_q;
    pend_glyph_d = pend_glyph_q;
    pend_blank_d = pend_blank_q;
    pend_vld_d   = pend_vld_q;

    if (tc) begin
      slot_d = '0;
      idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    // Active buffer only changes at the frame boundary; a load on that same
    // cycle is newer than anything pending, so it bypasses straight in.
    if (wrap) begin
      pend_vld_d = 1'b0;
      if (load) begin
        act_glyph_d = bus_glyph;
        act_blank_d = blank_mask;
      end else if (pend_vld_q) begin
        act_glyph_d = pend_glyph_q;
        act_blank_d = pend_blank_q;
      end
    end else if (load) begin
      pend_glyph_d = bus_glyph;
      pend_blank_d = blank_mask;
      pend_vld_d   = 1'b1;
    end

    // Blanked digits keep their anode slot so every digit has equal duty.
    seg_d = (act_blank_q[idx_q] || blink_hide) ? SEG_OFF : rom_seg;
    an_d  = (slot_q < GUARD_END) ? '1 : ~(NUM_DIGITS'(1) << idx_q);
    fd_d  = wrap;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q       <= '0;
      idx_q        <= '0;
      act_glyph_q  <= {NUM_DIGITS{GLYPH_BLANK}};
      pend_glyph_q <= {NUM_DIGITS{GLYPH_BLANK}};
      act_blank_q  <= '0;
      pend_blank_q <= '0;
      pend_vld_q   <= 1'b0;
      seg_q        <= SEG_OFF;
      an_q         <= '1;
      fd_q         <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      idx_q        <= idx_d;
      act_glyph_q  <= act_glyph_d;
      pend_glyph_q <= pend_glyph_d;
      act_blank_q  <= act_blank_d;
      pend_blank_q <= pend_blank_d;
      pend_vld_q   <= pend_vld_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      fd_q         <= fd_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver with NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYC=2.
// A time-based reference model (cycle count -> slot/digit by division) plus
// the double-buffer rules predicts seg/an/frame_done every cycle.
module tb_seg_scan_driver;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int GC = 2;
  localparam int FRAME = ND * RD;

  localparam logic [6:0] PAT [16] = '{
    7'b1110001, 7'b1000001, 7'b0111000, 7'b0000001,
    7'b0011000, 7'b0110000, 7'b1101010, 7'b1111110,
    7'b0001000, 7'b0110001, 7'b1001000, 7'b1111010,
    7'b1110000, 7'b1000010, 7'b0100100, 7'b1111111
  };

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [15:0]   glyph_bus = '0;
  logic          load = 1'b0;
  logic [3:0]    blank_mask = '0;
  logic [6:0]    seg;
  logic [3:0]    an;
  logic          frame_done;
`ifdef SEG_BLINK_EN
  logic [3:0]    blink_mask = '0;
`endif

  always #5 clk = ~clk;

  seg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .GUARD_CYC(GC)) dut (
    .clk        (clk),
    .reset      (reset),
    .glyph_bus  (glyph_bus),
    .load       (load),
    .blank_mask (blank_mask),
`ifdef SEG_BLINK_EN
    .blink_mask (blink_mask),
`endif
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  // reference model state
  int         mt;
  logic [3:0] m_act [ND];
  logic [3:0] m_pend [ND];
  logic [3:0] m_actb, m_pendb;
  bit         m_pv;
  logic [6:0] exp_seg;
  logic [3:0] exp_an;
  logic       exp_fd;

  int  n_assert = 0;
  int  n_fail = 0;
  bit  p_seen;
  int  fd_cnt, an0_cnt;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mt = 0;
    for (int i = 0; i < ND; i++) begin m_act[i] = 4'hF; m_pend[i] = 4'hF; end
    m_actb = '0; m_pendb = '0; m_pv = 0;
    exp_seg = 7'h7F; exp_an = 4'hF; exp_fd = 1'b0;
  endtask

  // Outputs after this edge describe the position held just before it.
  task automatic model_edge();
    int slot, dig;
    slot = mt % RD;
    dig  = (mt / RD) % ND;
    exp_an  = (slot < GC) ? 4'hF : ~(4'b0001 << dig);
    exp_seg = m_actb[dig] ? 7'h7F : PAT[m_act[dig]];
    exp_fd  = (slot == RD - 1) && (dig == ND - 1);
    if (exp_fd) begin
      if (load) begin
        for (int i = 0; i < ND; i++) m_act[i] = glyph_bus[4*i +: 4];
        m_actb = blank_mask;
      end else if (m_pv) begin
        for (int i = 0; i < ND; i++) m_act[i] = m_pend[i];
        m_actb = m_pendb;
      end
      m_pv = 0;
    end else if (load) begin
      for (int i = 0; i < ND; i++) m_pend[i] = glyph_bus[4*i +: 4];
      m_pendb = blank_mask;
      m_pv = 1;
    end
    mt++;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("seg", seg, exp_seg);
    chk("an", {3'b0, an}, {3'b0, exp_an});
    chk("frame_done", {6'b0, frame_done}, {6'b0, exp_fd});
    if (frame_done) fd_cnt++;
    if (an == 4'b1110) an0_cnt++;
    if (an != 4'hF && seg == PAT[4]) p_seen = 1;
  endtask

  task automatic do_load(input logic [15:0] bus, input logic [3:0] mask);
    glyph_bus = bus; blank_mask = mask; load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  // advance until mt % FRAME == target (bounded)
  task automatic run_to(input int target);
    int n = 0;
    while ((mt % FRAME) != target && n < 2 * FRAME) begin cyc(); n++; end
    n_assert++;
    assert ((mt % FRAME) == target) else begin
      n_fail++;
      $error("FAIL run_to: observed %0d expected %0d", mt % FRAME, target);
    end
  endtask

  initial begin
    model_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_an", {3'b0, an}, 7'h0F);
    chk("rst_fd", {6'b0, frame_done}, 7'h00);
    reset = 1'b0;

    // 1: idle scan, blanks only
    fd_cnt = 0; an0_cnt = 0;
    repeat (32) cyc();
    chk("digit0_duty", 7'(an0_cnt), 7'd6);
    repeat (32) cyc();
    chk("fd_count", 7'(fd_cnt), 7'd2);

    // 2: load mid-frame, visible only after the wrap
    run_to(10);
    do_load(16'h3210, 4'b0000);
    run_to(20);
    chk("no_tear", seg, 7'h7F);
    run_to(0);
    run_to(5);
    chk("dig0_L", seg, 7'b1110001);
    run_to(29);
    chk("dig3_O", seg, 7'b0000001);

    // 3: last load of the frame wins
    run_to(3);
    do_load(16'h4444, 4'b0000);
    run_to(10);
    do_load(16'h5555, 4'b0000);
    p_seen = 0;
    run_to(0);
    run_to(5);
    chk("dig0_E", seg, 7'b0110000);
    run_to(0);
    chk("p_never", {6'b0, p_seen}, 7'd0);

    // 4: load on the wrap cycle takes effect for the new frame
    run_to(31);
    do_load(16'h6666, 4'b0000);
    run_to(5);
    chk("wrap_load_n", seg, 7'b1101010);

    // 5: per-digit blank
    run_to(8);
    do_load(16'h6666, 4'b0100);
    run_to(0);
    run_to(21);
    chk("blank_seg", seg, 7'h7F);
    chk("blank_an", {3'b0, an}, 7'b0001011);
    run_to(13);
    chk("unblank_dig1", seg, 7'b1101010);

    // 6: reset during digit 2 with an update pending
    do_load(16'h8888, 4'b0000);
    run_to(19);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_seg", seg, 7'h7F);
    chk("mid_rst_an", {3'b0, an}, 7'h0F);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (5) cyc();
    chk("restart_an", {3'b0, an}, 7'b0001110);
    repeat (40) cyc();
    chk("pend_dropped", seg, 7'h7F);

    // random loads against the model
    repeat (400) begin
      if ($urandom_range(0, 7) == 0)
        do_load(16'($urandom), 4'($urandom));
      else
        cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
